// File: rtl/bmf_pkg.sv
// bmf_pkg: shared types and constants for the Boolean-matrix-factorised stream decoder
package bmf_pkg;
  typedef enum logic {CONFIG, RUN} bmf_state_t;
  localparam int SEMI_OR = 0;
  localparam int SEMI_XOR = 1;
  localparam int BMF_K = 3;
  localparam int BMF_M = 4;
endpackage

// File: rtl/bmf_bool_product.sv
// bmf_bool_product: Boolean product of a latent vector with a K x M basis matrix
module bmf_bool_product
  import bmf_pkg::*;
#(
  parameter int K = BMF_K,
  parameter int M = BMF_M,
  parameter int XOR_MODE = SEMI_OR
) (
  input  logic [K-1:0]   k,
  input  logic [K*M-1:0] h,
  output logic [M-1:0]   product
);
  always_comb begin
    product = '0;
    for (int i = 0; i < K; i++)
      product = (XOR_MODE == SEMI_XOR) ? product ^ (k[i] ? h[i*M+:M] : '0) : product | (k[i] ? h[i*M+:M] : '0);
  end
endmodule

// File: rtl/bmf_stream_decoder.sv
// bmf_stream_decoder: streaming Boolean-matrix-factorisation decompressor with accuracy monitor
module bmf_stream_decoder
  import bmf_pkg::*;
#(
  parameter int K = BMF_K,
  parameter int M = BMF_M,
  parameter int XOR_MODE = SEMI_OR,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [(K > 1 ? $clog2(K) : 1)-1:0] cfg_row,
  input  logic [M-1:0]                   cfg_data,
  input  logic                           cfg_start,
  output logic                           busy,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [K-1:0]                   in_k,
  input  logic [M-1:0]                   in_exact,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [M-1:0]                   out_data,
  output logic                           out_mismatch,
  input  logic                           err_clear,
  output logic [CNT_W-1:0]               err_count
);
  bmf_state_t state, state_d;
  logic [K*M-1:0] h;
  logic [K-1:0] s1_k;
  logic [M-1:0] s1_exact, s2_data, prod;
  logic s1_valid, s2_valid, s2_mis, adv1, adv2, in_hs, out_hs;
  assign adv2 = !s2_valid || out_ready;
  assign adv1 = !s1_valid || adv2;
  assign busy = state == RUN;
  assign in_ready = busy && adv1;
  assign in_hs = in_valid && in_ready;
  assign out_hs = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign out_data = s2_data;
  assign out_mismatch = s2_valid && s2_mis;
  bmf_bool_product #(.K(K), .M(M), .XOR_MODE(XOR_MODE)) u_prod (
    .k(s1_k),
    .h(h),
    .product(prod)
  );
  always_comb state_d = (state == CONFIG && cfg_start) ? RUN : state;
  always_ff @(posedge clk) state <= rst ? CONFIG : state_d;
  always_ff @(posedge clk)
    if (rst) h <= '0;
    else if (!busy && cfg_we)
      for (int i = 0; i < K; i++)
        if (int'(cfg_row) == i) h[i*M+:M] <= cfg_data;
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_k <= '0;
      s1_exact <= '0;
      s2_valid <= 1'b0;
      s2_data <= '0;
      s2_mis <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_hs;
        if (in_hs) begin
          s1_k <= in_k;
          s1_exact <= in_exact;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= prod;
          s2_mis <= prod != s1_exact;
        end
      end
    end
  always_ff @(posedge clk)
    if (rst || err_clear) err_count <= '0;
    else if (out_hs && s2_mis && !(&err_count)) err_count <= err_count + 1'b1;
endmodule
